// File: rtl/pipeline_hazard_controller.sv
// Hazard and sequencing control for the 5-stage pipeline: stalls, flushes,
// E-stage forwarding selects, multicycle-op sequencing and a stall-cycle counter.
module pipeline_hazard_controller #(
    parameter int MD_LATENCY = 4,
    parameter int CNT_W      = 32
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [4:0]       Rs1D,
    input  logic [4:0]       Rs2D,
    input  logic [4:0]       Rs1E,
    input  logic [4:0]       Rs2E,
    input  logic [4:0]       RdE,
    input  logic [4:0]       RdM,
    input  logic [4:0]       RdW,
    input  logic             LoadE,
    input  logic             RegWriteM,
    input  logic             RegWriteW,
    input  logic             PCSrcE,
    input  logic             MdOpE,
    input  logic             imem_ready,
    output logic             StallF,
    output logic             StallD,
    output logic             FlushD,
    output logic             StallE,
    output logic             FlushE,
    output logic             FlushM,
    output logic [1:0]       ForwardAE,
    output logic [1:0]       ForwardBE,
    output logic             md_done,
    output logic [CNT_W-1:0] stall_cnt
);

    // state   | meaning
    // RUN     | normal issue; hazards resolved by priority each cycle
    // MD_BUSY | multicycle op occupying E; md_cnt counts remaining stall cycles
    typedef enum logic {RUN, MD_BUSY} state_t;

    localparam logic [3:0] MD_INIT = 4'(MD_LATENCY - 2);

    state_t     state_q, state_d;
    logic [3:0] md_cnt_q, md_cnt_d;
    logic       lw_stall;

    assign lw_stall = LoadE && (RdE != 5'd0) && ((RdE == Rs1D) || (RdE == Rs2D));

    // Outputs are held low for the whole time reset is asserted, forwarding included.
    always_comb begin
        ForwardAE = 2'b00;
        ForwardBE = 2'b00;
        if (reset_n) begin
            if (RegWriteM && (RdM != 5'd0) && (RdM == Rs1E))
                ForwardAE = 2'b10;
            else if (RegWriteW && (RdW != 5'd0) && (RdW == Rs1E))
                ForwardAE = 2'b01;

            if (RegWriteM && (RdM != 5'd0) && (RdM == Rs2E))
                ForwardBE = 2'b10;
            else if (RegWriteW && (RdW != 5'd0) && (RdW == Rs2E))
                ForwardBE = 2'b01;
        end
    end

    always_comb begin
        state_d  = state_q;
        md_cnt_d = md_cnt_q;
        StallF   = 1'b0;
        StallD   = 1'b0;
        FlushD   = 1'b0;
        StallE   = 1'b0;
        FlushE   = 1'b0;
        FlushM   = 1'b0;
        md_done  = 1'b0;
        if (reset_n) begin
            case (state_q)
                RUN: begin
                    if (PCSrcE) begin
                        FlushD = 1'b1;
                        FlushE = 1'b1;
                    end else if (MdOpE) begin
                        StallF   = 1'b1;
                        StallD   = 1'b1;
                        StallE   = 1'b1;
                        FlushM   = 1'b1;
                        state_d  = MD_BUSY;
                        md_cnt_d = MD_INIT;
                    end else if (lw_stall || !imem_ready) begin
                        StallF = 1'b1;
                        StallD = 1'b1;
                        FlushE = 1'b1;
                    end
                end
                MD_BUSY: begin
                    if (md_cnt_q != 4'd0) begin
                        StallF   = 1'b1;
                        StallD   = 1'b1;
                        StallE   = 1'b1;
                        FlushM   = 1'b1;
                        md_cnt_d = md_cnt_q - 4'd1;
                    end else begin
                        md_done = 1'b1;
                        state_d = RUN;
                        if (!imem_ready) begin
                            StallF = 1'b1;
                            StallD = 1'b1;
                            FlushE = 1'b1;
                        end
                    end
                end
                default: state_d = RUN;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= RUN;
            md_cnt_q <= 4'd0;
        end else begin
            state_q  <= state_d;
            md_cnt_q <= md_cnt_d;
        end
    end

    // Saturating: a wrapped counter would misreport long stall bursts as short ones.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            stall_cnt <= '0;
        else if (StallD && (stall_cnt != {CNT_W{1'b1}}))
            stall_cnt <= stall_cnt + CNT_W'(1);
    end

endmodule
